// File: rtl/pixel_fb_scanout.sv
// pixel_fb_scanout: 160x120x3 frame buffer fed by the draw engine's
// plot port, with a whole-screen clear engine and 4x-scaled VGA scan-out.
// Ports:
//   clk, resetn (sync, active-low)
//   plot/x/y/colour  pixel write port; wr_drop pulses on a discarded write
//   clear/busy       start / progress of a fill with BG_COLOUR
//   frame_start      pulse when the scan counters enter (0,0)
//   vga_*            DAC pins (r/g/b, hs, vs, blank_n, sync_n, clk)
module pixel_fb_scanout #(
  parameter int FB_W = 160,
  parameter int FB_H = 120,
  parameter int SCALE_SH = 2,
  parameter int CLK_DIV = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       clear,
  output logic       busy,
  output logic       wr_drop,
  output logic       frame_start,
  output logic [9:0] vga_r,
  output logic [9:0] vga_g,
  output logic [9:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk
);

  localparam int DEPTH = FB_W * FB_H;
  localparam int AW = $clog2(DEPTH);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  localparam logic [9:0] H_LAST =
    10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST =
    10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

  // pixel tick
  logic [DW-1:0] div;
  logic [DW-1:0] div_nxt;
  logic          pix_en;

  assign pix_en  = (div == DIV_LAST);
  assign div_nxt = pix_en ? '0 : div + DW'(1);

  // vga_clk follows div so its falling edge lines up with pix_en
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div     <= '0;
      vga_clk <= 1'b0;
    end else begin
      div     <= div_nxt;
      vga_clk <= (div_nxt >= DIV_HALF);
    end
  end

  // scan counters
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       v_wrap;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && h_wrap && v_wrap;
      if (pix_en) begin
        h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
        if (h_wrap)
          v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
      end
    end
  end

  // stage 0 decode
  logic          hs0;
  logic          vs0;
  logic          act0;
  logic [AW-1:0] rd_addr;

  assign hs0  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs0  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  assign act0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);

  assign rd_addr = AW'(32'(v_cnt >> SCALE_SH) * FB_W
                     + 32'(h_cnt >> SCALE_SH));

  // clear FSM
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] clr_addr;
  logic          clr_we;

  always_ff @(posedge clk) begin
    if (!resetn)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (clear) state_nxt = S_CLEAR;
      S_CLEAR: if (clr_addr == ADDR_LAST) state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == S_CLEAR);
    clr_we = (state == S_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!resetn || state == S_IDLE)
      clr_addr <= '0;
    else
      clr_addr <= clr_addr + AW'(1);
  end

  // write port
  logic          in_rng;
  logic          plot_ok;
  logic [AW-1:0] plot_addr;
  logic          we;
  logic [AW-1:0] wa;
  logic [2:0]    wd;

  assign in_rng    = (32'(x) < FB_W) && (32'(y) < FB_H);
  assign plot_ok   = plot && in_rng && (state == S_IDLE);
  assign plot_addr = AW'(32'(y) * FB_W + 32'(x));

  // resetn gates the write so a reset cycle never lands a write
  always_comb begin
    we = 1'b0;
    wa = plot_addr;
    wd = colour;
    unique case (1'b1)
      clr_we: begin
        we = resetn;
        wa = clr_addr;
        wd = BG_COLOUR;
      end
      plot_ok: we = resetn;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      wr_drop <= 1'b0;
    else
      wr_drop <= plot && !plot_ok;
  end

  // frame buffer: read-before-write on a shared address
  logic [2:0] mem [DEPTH];
  logic [2:0] rd_data;

  always_ff @(posedge clk) begin
    if (we)
      mem[wa] <= wd;
    if (pix_en && act0)
      rd_data <= mem[rd_addr];
  end

  // stage 1 / output stage
  logic       hs1;
  logic       vs1;
  logic       act1;
  logic [2:0] rgb;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hs1         <= 1'b1;
      vs1         <= 1'b1;
      act1        <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      rgb         <= 3'b000;
    end else if (pix_en) begin
      hs1         <= hs0;
      vs1         <= vs0;
      act1        <= act0;
      vga_hs      <= hs1;
      vga_vs      <= vs1;
      vga_blank_n <= act1;
      rgb         <= act1 ? rd_data : 3'b000;
    end
  end

  assign vga_r      = {10{rgb[2]}};
  assign vga_g      = {10{rgb[1]}};
  assign vga_b      = {10{rgb[0]}};
  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_pixel_fb_scanout.sv
// tb_pixel_fb_scanout: directed bench for pixel_fb_scanout.
// dut uses a shrunk raster (56x28 totals); dut0 keeps default timing.
module tb_pixel_fb_scanout;

  localparam int HT  = 56;
  localparam int VT  = 28;
  localparam int NPX = HT * VT;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       plot = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;

  logic       busy, wr_drop, frame_start;
  logic [9:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n;
  logic       vga_sync_n, vga_clk;

  logic       d0_busy, d0_drop, d0_fs;
  logic [9:0] d0_r, d0_g, d0_b;
  logic       d0_hs, d0_vs, d0_bn, d0_sn, d0_clk;

  always #5 clk = ~clk;

  pixel_fb_scanout #(
    .H_ACTIVE(48), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(24), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk(clk), .resetn(resetn), .plot(plot),
    .x(x), .y(y), .colour(colour), .clear(clear),
    .busy(busy), .wr_drop(wr_drop),
    .frame_start(frame_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .vga_clk(vga_clk)
  );

  pixel_fb_scanout dut0 (
    .clk(clk), .resetn(resetn), .plot(plot),
    .x(x), .y(y), .colour(colour), .clear(clear),
    .busy(d0_busy), .wr_drop(d0_drop),
    .frame_start(d0_fs),
    .vga_r(d0_r), .vga_g(d0_g), .vga_b(d0_b),
    .vga_hs(d0_hs), .vga_vs(d0_vs),
    .vga_blank_n(d0_bn),
    .vga_sync_n(d0_sn), .vga_clk(d0_clk)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return d0_hs;
      1:       return vga_hs;
      default: return vga_vs;
    endcase
  endfunction

  // low width / period of a sync, in clk cycles
  task automatic meas(input int sel, output int lo,
                      output int per, output int fs);
    logic prev, cur;
    int n;
    lo = 0; per = 0; fs = 0; n = 0;
    @(negedge clk);
    cur = sig(sel);
    do begin
      prev = cur;
      @(negedge clk);
      cur = sig(sel);
      n++;
    end while (!(prev && !cur) && n < 20000);
    if (n >= 20000) return;
    lo = 1; per = 1; fs = int'(frame_start);
    n = 0;
    forever begin
      @(negedge clk);
      prev = cur;
      cur = sig(sel);
      if ((prev && !cur) || n >= 20000) break;
      per++; n++;
      if (!cur) lo++;
      if (frame_start) fs++;
    end
  endtask

  task automatic wr_px(input int px, input int py,
                       input int pc, output logic drop);
    @(negedge clk);
    plot = 1'b1;
    x = 8'(px);
    y = 7'(py);
    colour = 3'(pc);
    @(negedge clk);
    drop = wr_drop;
    plot = 1'b0;
  endtask

  task automatic do_clear(input bit mid_plot,
                          output int cnt, output logic drop);
    cnt = 0;
    drop = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    while (busy === 1'b1 && cnt < 20000) begin
      cnt++;
      if (mid_plot && cnt == 200) begin
        plot = 1'b1; x = 8'd2; y = 7'd0; colour = 3'd7;
      end else if (mid_plot && cnt == 201) begin
        drop = wr_drop;
        plot = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  // one output sample per pixel, aligned to (h,v)
  logic [30:0] cap [NPX];
  logic        cap_hs [NPX];
  logic        cap_vs [NPX];

  task automatic capture();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 4000);
    chk("frame_start", 64'(frame_start), 64'(1));
    repeat (5) @(negedge clk);
    for (int p = 0; p < NPX; p++) begin
      if (p != 0) repeat (2) @(negedge clk);
      cap[p] = {vga_blank_n, vga_r, vga_g, vga_b};
      cap_hs[p] = vga_hs;
      cap_vs[p] = vga_vs;
    end
  endtask

  function automatic logic [30:0] expv(input logic bn,
                                       input logic [2:0] c);
    return {bn, {10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
  endfunction

  task automatic chk_px(input string tag, input int h,
                        input int v, input logic bn,
                        input logic [2:0] c);
    chk(tag, 64'(cap[v*HT+h]), 64'(expv(bn, c)));
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int lo, per, fs, cnt;
    logic drop;

    repeat (5) @(negedge clk);
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst wr_drop", 64'(wr_drop), 64'(0));
    chk("rst frame_start", 64'(frame_start), 64'(0));
    chk("rst hs", 64'(vga_hs), 64'(1));
    chk("rst vs", 64'(vga_vs), 64'(1));
    chk("rst blank_n", 64'(vga_blank_n), 64'(0));
    chk("rst vga_clk", 64'(vga_clk), 64'(0));
    chk("rst rgb", 64'({vga_r, vga_g, vga_b}), 64'(0));
    chk("sync_n", 64'(vga_sync_n), 64'(0));
    resetn = 1'b1;

    meas(0, lo, per, fs);
    chk("d0 hs low", 64'(lo), 64'(192));
    chk("d0 hs period", 64'(per), 64'(1600));
    meas(1, lo, per, fs);
    chk("hs low", 64'(lo), 64'(8));
    chk("hs period", 64'(per), 64'(112));
    meas(2, lo, per, fs);
    chk("vs low", 64'(lo), 64'(224));
    chk("vs period", 64'(per), 64'(3136));
    chk("fs per frame", 64'(fs), 64'(1));

    do_clear(1'b0, cnt, drop);
    chk("busy len 1", 64'(cnt), 64'(19200));

    wr_px(3, 3, 6, drop);
    chk("drop 3,3", 64'(drop), 64'(0));
    wr_px(160, 0, 7, drop);
    chk("drop x160", 64'(drop), 64'(1));
    wr_px(0, 120, 7, drop);
    chk("drop y120", 64'(drop), 64'(1));
    wr_px(159, 119, 5, drop);
    chk("drop 159,119", 64'(drop), 64'(0));
    chk("mem 19199", 64'(dut.mem[19199]), 64'(5));
    chk("mem 160", 64'(dut.mem[160]), 64'(0));
    wr_px(11, 0, 7, drop);
    wr_px(12, 0, 7, drop);
    wr_px(0, 6, 7, drop);

    capture();
    chk_px("px 12,12", 12, 12, 1'b1, 3'b110);
    chk_px("px 15,15", 15, 15, 1'b1, 3'b110);
    chk_px("px 11,12", 11, 12, 1'b1, 3'b000);
    chk_px("px 16,15", 16, 15, 1'b1, 3'b000);
    chk_px("px 12,11", 12, 11, 1'b1, 3'b000);
    chk_px("px 12,16", 12, 16, 1'b1, 3'b000);
    chk_px("px 0,4", 0, 4, 1'b1, 3'b000);
    chk_px("px 44,0", 44, 0, 1'b1, 3'b111);
    chk_px("px 47,3", 47, 3, 1'b1, 3'b111);
    chk_px("blank h48", 48, 0, 1'b0, 3'b000);
    chk_px("blank v24", 0, 24, 1'b0, 3'b000);
    chk_px("px 0,23", 0, 23, 1'b1, 3'b000);
    chk("hs 49", 64'(cap_hs[49]), 64'(1));
    chk("hs 50", 64'(cap_hs[50]), 64'(0));
    chk("hs 53", 64'(cap_hs[53]), 64'(0));
    chk("hs 54", 64'(cap_hs[54]), 64'(1));
    chk("vs 24", 64'(cap_vs[24*HT]), 64'(1));
    chk("vs 25", 64'(cap_vs[25*HT]), 64'(0));
    chk("vs 27", 64'(cap_vs[27*HT]), 64'(1));

    do_clear(1'b1, cnt, drop);
    chk("busy len 2", 64'(cnt), 64'(19200));
    chk("drop in clear", 64'(drop), 64'(1));
    chk("mem 19199 clr", 64'(dut.mem[19199]), 64'(0));

    capture();
    chk_px("clr 12,12", 12, 12, 1'b1, 3'b000);
    chk_px("clr 8,0", 8, 0, 1'b1, 3'b000);
    chk_px("clr 44,0", 44, 0, 1'b1, 3'b000);

    wr_px(39, 31, 7, drop);
    wr_px(40, 31, 7, drop);
    wr_px(159, 119, 7, drop);

    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    cnt = 1;
    while (cnt < 5001 && busy === 1'b1) begin
      @(negedge clk);
      cnt++;
    end
    chk("clr_addr", 64'(dut.clr_addr), 64'(5000));
    resetn = 1'b0;
    @(negedge clk);
    chk("rst busy mid", 64'(busy), 64'(0));
    chk("rst blank mid", 64'(vga_blank_n), 64'(0));
    chk("rst hs mid", 64'(vga_hs), 64'(1));
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle after rst", 64'(busy), 64'(0));
    chk("mem 4999", 64'(dut.mem[4999]), 64'(0));
    chk("mem 5000", 64'(dut.mem[5000]), 64'(7));
    chk("mem 19199 old", 64'(dut.mem[19199]), 64'(7));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
